// File: rtl/chirp_sequencer_if.sv
// Control/status bundle between the frame controller and whatever drives it.
// master drives config and requests; slave is the sequencer itself.
interface chirp_sequencer_if #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned IDX_W = 16
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] chirp_len;
  logic [CNT_W-1:0] pri;
  logic [CNT_W-1:0] rx_delay;
  logic [CNT_W-1:0] rx_len;
  logic [IDX_W-1:0] num_chirps;
  logic             gen;
  logic             tx_en;
  logic             rx_en;
  logic [IDX_W-1:0] chirp_idx;
  logic             busy;
  logic             frame_done;
  logic             cfg_err;

  modport master (
    output start, abort, chirp_len, pri, rx_delay, rx_len, num_chirps,
    input  gen, tx_en, rx_en, chirp_idx, busy, frame_done, cfg_err
  );

  modport slave (
    input  start, abort, chirp_len, pri, rx_delay, rx_len, num_chirps,
    output gen, tx_en, rx_en, chirp_idx, busy, frame_done, cfg_err
  );
endinterface

// File: rtl/chirp_sequencer.sv
// Frame-level chirp timing: gen pulses every PRI for num_chirps chirps, with TX/RX gates
// aligned to each chirp. All outputs are registered.
module chirp_sequencer #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned IDX_W = 16
) (
  input logic              clk,
  input logic              rst,
  chirp_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] p_q, p_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] len_q, len_d, pri_q, pri_d, rxd_q, rxd_d, rxl_q, rxl_d;
  logic [IDX_W-1:0] num_q, num_d;
  logic             gen_q, gen_d, tx_q, tx_d, rx_q, rx_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             cfg_bad;
  logic             act;
  logic [CNT_W:0]   rx_end_d;

  // Window end is computed one bit wider so a huge rx_delay cannot wrap into range.
  assign cfg_bad = (bus.num_chirps == '0) || (bus.chirp_len == '0) ||
                   (bus.pri < bus.chirp_len) ||
                   ((bus.rx_len != '0) &&
                    (({1'b0, bus.rx_delay} + {1'b0, bus.rx_len}) > {1'b0, bus.pri}));

  assign rx_end_d = {1'b0, rxd_d} + {1'b0, rxl_d};

  always_comb begin
    len_d = len_q;
    pri_d = pri_q;
    rxd_d = rxd_q;
    rxl_d = rxl_q;
    num_d = num_q;
    if (state_q == StIdle && bus.start && !bus.abort) begin
      len_d = bus.chirp_len;
      pri_d = bus.pri;
      rxd_d = bus.rx_delay;
      rxl_d = bus.rx_len;
      num_d = bus.num_chirps;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    idx_d   = idx_q;
    act     = 1'b0;
    gen_d   = 1'b0;
    tx_d    = 1'b0;
    rx_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.abort) begin
      state_d = StIdle;
      p_d     = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (cfg_bad) begin
              err_d = 1'b1;
            end else begin
              state_d = StRun;
              p_d     = '0;
              idx_d   = '0;
              act     = 1'b1;
            end
          end
        end
        StRun: begin
          if (p_q == pri_q - CNT_W'(1)) begin
            if (idx_q == num_q - IDX_W'(1)) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              p_d   = '0;
              idx_d = idx_q + IDX_W'(1);
              act   = 1'b1;
            end
          end else begin
            p_d = p_q + CNT_W'(1);
            act = 1'b1;
          end
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
    // Gates are decoded from the counter value that will be live next cycle.
    if (act) begin
      busy_d = 1'b1;
      gen_d  = (p_d == '0);
      tx_d   = (p_d < len_d);
      rx_d   = (rxl_d != '0) && (p_d >= rxd_d) && ({1'b0, p_d} < rx_end_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      p_q     <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      pri_q   <= '0;
      rxd_q   <= '0;
      rxl_q   <= '0;
      num_q   <= '0;
      gen_q   <= 1'b0;
      tx_q    <= 1'b0;
      rx_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pri_q   <= pri_d;
      rxd_q   <= rxd_d;
      rxl_q   <= rxl_d;
      num_q   <= num_d;
      gen_q   <= gen_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.gen        = gen_q;
  assign bus.tx_en      = tx_q;
  assign bus.rx_en      = rx_q;
  assign bus.chirp_idx  = idx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.cfg_err    = err_q;

endmodule
